fu_scoreboard: RTL
==================

# fu_scoreboard

Parametrised issue scoreboard and writeback arbiter for the pipelined core's multi-cycle execution units (FALU add/sub/mul/div and future units). It succeeds the fixed int/fp forwarding/stall hazard unit and sits between decode (D) and execute. It tracks pending destination registers across `NFILES` register files, stalls D on RAW, WAW and structural hazards, counts per-unit latency, and arbitrates a single shared register-file write port among finishing units.

## Interface
- `NUNITS`, 2: number of non-pipelined multi-cycle units.
- `NFILES`, 2: number of register files (0 = int, 1 = fp).
- `NREGS`, 32: registers per file.
- `LATW`, 5: width of the latency field.
- `ZERO_FILE`, 0: file whose register 0 is hardwired to zero.
- Derived: `UW=$clog2(NUNITS)`, `FW=$clog2(NFILES)`, `RW=$clog2(NREGS)`.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `flush`  in  1  kills the D-stage issue this cycle; in-flight units are unaffected.
- `iss_valid`  in  1  D holds a multi-cycle op.
- `iss_unit`  in  UW  target unit.
- `iss_lat`  in  LATW  unit latency in cycles; 0 is treated as 1.
- `iss_rd`, `iss_rd_file`, `iss_rd_we`  in  RW/FW/1  destination.
- `iss_rs1`, `iss_rs1_file`, `iss_rs1_use`  in  RW/FW/1  source 1.
- `iss_rs2`, `iss_rs2_file`, `iss_rs2_use`  in  RW/FW/1  source 2.
- `iss_stall`  out  1  hold F/D.
- `iss_fire`  out  1  issue accepted this cycle.
- `unit_busy`  out  NUNITS  per-unit occupancy (registered).
- `wb_ready`  in  1  shared write port is free (low while the main pipeline's W stage writes).
- `wb_valid`, `wb_unit`, `wb_rd`, `wb_file`, `wb_we`  out  1/UW/RW/FW/1  granted writeback.

## Operation
- State:
  - `pend[NFILES][NREGS]` bits.
  - Per unit: `busy`, `cnt[LATW]`, and a latched `rd`, `file`, `we`.
- Hazard rules. Combinational and computed from registered state only (no same-cycle bypass). `iss_stall = iss_valid & ~flush & (RAW | WAW | STRUCT)`:
  - RAW: `rsX_use & pend[rsX_file][rsX]`.
  - WAW: `rd_we & pend[rd_file][rd]`.
  - STRUCT: `busy[iss_unit]`.
- `iss_fire = iss_valid & ~flush & ~iss_stall`. On fire:
  - `busy[u] <= 1` and `cnt[u] <= max(iss_lat, 1)`.
  - Latch `rd`, `file`, `we`.
  - Set the pend bit if `rd_we`, unless `file==ZERO_FILE && rd==0`.
- Counting: while `busy[u] & cnt[u] > 1`, `cnt` decrements each cycle. `cnt[u]` saturates at 1.
- Writeback requests and grant:
  - `req[u] = busy[u] & (cnt[u]==1)`.
  - Grant goes to the lowest-index requesting unit when `wb_ready`.
  - `wb_valid = |req & wb_ready`. The `wb_*` outputs carry the grantee's latched fields.
- On grant, at the clock edge: clear `busy[u]` and clear its pend bit if `we`. Ungranted requesters hold their state (`cnt` stays 1).
- A granted op with `we=0` still asserts `wb_valid` with `wb_we=0`, so the unit is released.
- A pend bit is never set and cleared in the same cycle (guaranteed by the WAW stall). Pend bits for `ZERO_FILE` reg 0 are always 0.

## Timing
- Reset: all `pend`, `busy`, `cnt` = 0. `iss_stall`, `iss_fire`, `wb_valid`, `wb_we` = 0. `wb_unit`, `wb_rd`, `wb_file` = 0.
- Latency:
  - Fire at cycle t with latency L: `wb_valid` is high at the earliest at t+L.
  - The grant frees the unit and the register at t+L+1.
  - A dependent op can fire at t+L+1 at the earliest.
- Back-pressure: `wb_ready=0` delays all grants one cycle per low cycle; no request is lost.
- Contention: simultaneous `req` from units 0 and 1 → unit 0 granted at cycle n, unit 1 at n+1.
- Flush with `iss_valid`: no state change, `iss_stall=0`.
- Reset asserted mid-operation: asynchronous clear of all state; in-flight results are discarded.

## Structure
- Shared package `fu_pkg`: `NFILES`, `NREGS`, file-index constants `FILE_INT=0` and `FILE_FP=1`, and an `iss_req_t` grouping of the `iss_*` fields.
- One sub-module, `fu_wb_arb`: fixed-priority one-hot arbiter over `req` gated by `wb_ready`, returning the grant index and valid.
- Per-unit counters are generated with a `for` loop in the top.

## Test plan
- Reset release, then fire unit 1 with L=4 to fp rd=5: `wb_valid` rises exactly 4 cycles later with `wb_unit=1`, `wb_file=1`, `wb_rd=5`. `pend[1][5]` is clear the following cycle.
- RAW: unit 0 writes int x7 with L=3; next cycle issue with rs1=x7 → `iss_stall` high for 3 cycles, `iss_fire` on cycle 4 after the original fire.
- Structural/WAW: unit 0 busy, issue again to unit 0 → stalled until the cycle after grant. Issue to int x0 with `we=1` → no pend set and no stall for later readers of x0.
- Contention: units 0 and 1 fire in the same window so both reach `cnt==1` at cycle n → grants unit 0 at n, unit 1 at n+1. Hold `wb_ready=0` for 2 cycles → both grants shift by 2.
- `flush` asserted with a valid issue → `iss_fire=0` and `unit_busy` unchanged. `iss_lat=0` → behaves as L=1.
- Assert `reset` low while both units are busy → all outputs 0 immediately (asynchronous). After release, a previously pending source does not stall.

Source files
------------

// File: rtl/fu_pkg.sv
// fu_pkg
// Shared definitions for the multi-cycle execution unit scoreboard.
//   NUNITS/NFILES/NREGS/LATW : default scoreboard geometry
//   UW/FW/RW                 : derived index widths for the default geometry
//   FILE_INT/FILE_FP         : register file indices
//   iss_req_t                : one D-stage issue request (valid, unit, latency,
//                              destination and both sources) at default widths
package fu_pkg;

    localparam int NUNITS = 2;
    localparam int NFILES = 2;
    localparam int NREGS  = 32;
    localparam int LATW   = 5;

    localparam int UW = (NUNITS > 1) ? $clog2(NUNITS) : 1;
    localparam int FW = (NFILES > 1) ? $clog2(NFILES) : 1;
    localparam int RW = $clog2(NREGS);

    localparam int FILE_INT = 0;
    localparam int FILE_FP  = 1;

    typedef struct packed {
        logic            valid;
        logic [UW-1:0]   unit;
        logic [LATW-1:0] lat;
        logic [RW-1:0]   rd;
        logic [FW-1:0]   rd_file;
        logic            rd_we;
        logic [RW-1:0]   rs1;
        logic [FW-1:0]   rs1_file;
        logic            rs1_use;
        logic [RW-1:0]   rs2;
        logic [FW-1:0]   rs2_file;
        logic            rs2_use;
    } iss_req_t;

endpackage

// File: rtl/fu_wb_arb.sv
// fu_wb_arb
// Fixed-priority arbiter for the shared register-file write port.
// The lowest-index requester wins; nothing is granted while the port is busy.
//   req_i   : per-unit writeback request
//   ready_i : shared write port is free this cycle
//   gnt_o   : one-hot grant
//   idx_o   : index of the granted unit (0 when nothing is granted)
//   valid_o : a grant is issued this cycle
module fu_wb_arb #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic          ready_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic found;

    // Scan upward and stop at the first requester so unit 0 always wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found   = 1'b0;
        valid_o = ready_i & (|req_i);
        for (int i = 0; i < N; i++) begin
            if (req_i[i] && ready_i && !found) begin
                gnt_o[i] = 1'b1;
                idx_o    = IW'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fu_scoreboard.sv
// fu_scoreboard
// Issue scoreboard and writeback arbiter for the non-pipelined multi-cycle units.
// Tracks pending destinations per register file, stalls decode on RAW/WAW/
// structural hazards, counts each unit's latency and hands the single shared
// write port to the lowest-index finishing unit.
//   clk, reset (async, active-low), flush (kills this cycle's issue)
//   iss_*      : decode-stage request (unit, latency, rd, rs1, rs2)
//   iss_stall  : hold fetch/decode
//   iss_fire   : request accepted this cycle
//   unit_busy  : registered per-unit occupancy
//   wb_ready   : shared write port free
//   wb_*       : granted writeback (valid, unit, rd, file, we)
module fu_scoreboard #(
    parameter int NUNITS    = fu_pkg::NUNITS,
    parameter int NFILES    = fu_pkg::NFILES,
    parameter int NREGS     = fu_pkg::NREGS,
    parameter int LATW      = fu_pkg::LATW,
    parameter int ZERO_FILE = fu_pkg::FILE_INT,
    localparam int UW = (NUNITS > 1) ? $clog2(NUNITS) : 1,
    localparam int FW = (NFILES > 1) ? $clog2(NFILES) : 1,
    localparam int RW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              iss_valid,
    input  logic [UW-1:0]     iss_unit,
    input  logic [LATW-1:0]   iss_lat,
    input  logic [RW-1:0]     iss_rd,
    input  logic [FW-1:0]     iss_rd_file,
    input  logic              iss_rd_we,
    input  logic [RW-1:0]     iss_rs1,
    input  logic [FW-1:0]     iss_rs1_file,
    input  logic              iss_rs1_use,
    input  logic [RW-1:0]     iss_rs2,
    input  logic [FW-1:0]     iss_rs2_file,
    input  logic              iss_rs2_use,
    output logic              iss_stall,
    output logic              iss_fire,
    output logic [NUNITS-1:0] unit_busy,
    input  logic              wb_ready,
    output logic              wb_valid,
    output logic [UW-1:0]     wb_unit,
    output logic [RW-1:0]     wb_rd,
    output logic [FW-1:0]     wb_file,
    output logic              wb_we
);

    logic [NREGS-1:0]  pend_q [NFILES];
    logic [NREGS-1:0]  pend_d [NFILES];
    logic [NUNITS-1:0] busy_q;
    logic [LATW-1:0]   cnt_q  [NUNITS];
    logic [RW-1:0]     rd_q   [NUNITS];
    logic [FW-1:0]     file_q [NUNITS];
    logic [NUNITS-1:0] we_q;

    logic [NUNITS-1:0] req;
    logic [NUNITS-1:0] gnt;
    logic [NUNITS-1:0] unit_fire;
    logic [UW-1:0]     gnt_idx;
    logic              gnt_valid;
    logic [LATW-1:0]   lat_eff;
    logic              hazard;
    logic              rd_is_zero;

    // Hazards look only at registered state: a result being granted this
    // cycle still blocks its readers until the following cycle.
    assign hazard = (iss_rs1_use & pend_q[iss_rs1_file][iss_rs1])
                  | (iss_rs2_use & pend_q[iss_rs2_file][iss_rs2])
                  | (iss_rd_we   & pend_q[iss_rd_file][iss_rd])
                  | busy_q[iss_unit];

    assign iss_stall = iss_valid & ~flush & hazard;
    assign iss_fire  = iss_valid & ~flush & ~hazard;

    // A zero latency would never reach the count of 1 that raises a request.
    assign lat_eff    = (iss_lat == '0) ? LATW'(1) : iss_lat;
    assign rd_is_zero = (iss_rd_file == FW'(ZERO_FILE)) && (iss_rd == '0);

    // Per-unit occupancy and latency countdown; cnt parks at 1 while the
    // unit waits for the write port, so a late grant never loses a result.
    for (genvar u = 0; u < NUNITS; u++) begin : g_unit
        assign unit_fire[u] = iss_fire && (iss_unit == UW'(u));
        assign req[u]       = busy_q[u] && (cnt_q[u] == LATW'(1));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                busy_q[u] <= 1'b0;
                cnt_q[u]  <= '0;
                rd_q[u]   <= '0;
                file_q[u] <= '0;
                we_q[u]   <= 1'b0;
            end else if (unit_fire[u]) begin
                busy_q[u] <= 1'b1;
                cnt_q[u]  <= lat_eff;
                rd_q[u]   <= iss_rd;
                file_q[u] <= iss_rd_file;
                we_q[u]   <= iss_rd_we;
            end else if (gnt[u]) begin
                busy_q[u] <= 1'b0;
            end else if (busy_q[u] && (cnt_q[u] > LATW'(1))) begin
                cnt_q[u]  <= cnt_q[u] - LATW'(1);
            end
        end
    end

    fu_wb_arb #(
        .N  (NUNITS),
        .IW (UW)
    ) u_wb_arb (
        .req_i   (req),
        .ready_i (wb_ready),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .valid_o (gnt_valid)
    );

    // Granted results release their destination; a new issue marks its own.
    // The WAW stall keeps these two from ever touching the same bit.
    always_comb begin
        pend_d = pend_q;
        for (int u = 0; u < NUNITS; u++) begin
            if (gnt[u] && we_q[u]) begin
                pend_d[file_q[u]][rd_q[u]] = 1'b0;
            end
        end
        if (iss_fire && iss_rd_we && !rd_is_zero) begin
            pend_d[iss_rd_file][iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int f = 0; f < NFILES; f++) begin
                pend_q[f] <= '0;
            end
        end else begin
            pend_q <= pend_d;
        end
    end

    // Writeback fields are zeroed when idle so the port shows no stale unit.
    assign unit_busy = busy_q;
    assign wb_valid  = gnt_valid;
    assign wb_unit   = gnt_valid ? gnt_idx         : '0;
    assign wb_rd     = gnt_valid ? rd_q[gnt_idx]   : '0;
    assign wb_file   = gnt_valid ? file_q[gnt_idx] : '0;
    assign wb_we     = gnt_valid & we_q[gnt_idx];

endmodule
